// File: rtl/wbuf_drain.sv
// wbuf_drain: drains the write-buffer compare FIFO onto a single-beat
// valid/ready memory write port.
//
// Ports:
//   sClk_i, sRst_i         clock, synchronous active-high reset
//   FifoEmpty_i            FIFO empty flag
//   FifoData_i             FIFO head entry {addr, data, strb}
//   FifoRead_o             pop strobe (combinational)
//   Hold_i                 blocks new pops; an outstanding write is unaffected
//   Flush_i                single-cycle flush request
//   FlushDone_o            one-cycle pulse when a flush completes
//   MemValid_o/MemReady_i  write request handshake
//   MemAddr_o/MemWData_o/MemWStrb_o  registered request payload
//   Busy_o                 engine active or FIFO non-empty
//   Error_o                sticky watchdog error
//   WrCount_o              completed writes, wraps
module wbuf_drain #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int W_STRB    = W_DATA/8,
  parameter int W_ENTRY   = W_ADDR+W_DATA+W_STRB,
  parameter int C_TIMEOUT = 256,
  parameter int W_CNT     = 16
) (
  input  logic               sClk_i,
  input  logic               sRst_i,
  input  logic               FifoEmpty_i,
  input  logic [W_ENTRY-1:0] FifoData_i,
  output logic               FifoRead_o,
  input  logic               Hold_i,
  input  logic               Flush_i,
  output logic               FlushDone_o,
  output logic               MemValid_o,
  input  logic               MemReady_i,
  output logic [W_ADDR-1:0]  MemAddr_o,
  output logic [W_DATA-1:0]  MemWData_o,
  output logic [W_STRB-1:0]  MemWStrb_o,
  output logic               Busy_o,
  output logic               Error_o,
  output logic [W_CNT-1:0]   WrCount_o
);

  localparam int W_WD = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

  state_t          state, state_nxt;
  logic            flush_pend_r, flush_pend;
  logic            pop_ok, pop, hs, done, wd_hit;
  logic [W_WD-1:0] wd;

  // A pending flush (including one arriving this cycle) overrides Hold_i.
  assign flush_pend = flush_pend_r | Flush_i;
  assign pop_ok     = ~FifoEmpty_i & (~Hold_i | flush_pend);
  assign hs         = (state == REQ) & MemReady_i;
  // Fires on the C_TIMEOUT-th consecutive unacknowledged REQ cycle.
  assign wd_hit     = (C_TIMEOUT > 0) && (wd == W_WD'(C_TIMEOUT-1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        pop  = pop_ok;
        done = flush_pend & FifoEmpty_i;
        if (pop_ok) state_nxt = REQ;
      end
      REQ: begin
        if (MemReady_i) begin
          // Pop only alongside a handshake so the payload never changes
          // while valid is waiting on ready.
          pop  = pop_ok;
          done = flush_pend & FifoEmpty_i;
          if (!pop_ok) state_nxt = IDLE;
        end else if (wd_hit) begin
          state_nxt = ERR;
        end
      end
      default: ;  // ERR is terminal until reset
    endcase
    if (sRst_i) pop = 1'b0;
  end

  always_ff @(posedge sClk_i) begin
    if (sRst_i) begin
      state        <= IDLE;
      MemAddr_o    <= '0;
      MemWData_o   <= '0;
      MemWStrb_o   <= '0;
      WrCount_o    <= '0;
      FlushDone_o  <= 1'b0;
      flush_pend_r <= 1'b0;
      wd           <= '0;
    end else begin
      state        <= state_nxt;
      FlushDone_o  <= done;
      flush_pend_r <= done ? 1'b0 : flush_pend;
      if (pop) begin
        MemAddr_o  <= FifoData_i[W_ENTRY-1:W_DATA+W_STRB];
        MemWData_o <= FifoData_i[W_DATA+W_STRB-1:W_STRB];
        MemWStrb_o <= FifoData_i[W_STRB-1:0];
      end
      if (hs) WrCount_o <= WrCount_o + 1'b1;
      if (pop || hs)      wd <= '0;
      else if (state == REQ) wd <= wd + 1'b1;
    end
  end

  assign FifoRead_o = pop;
  assign MemValid_o = (state == REQ);
  assign Error_o    = (state == ERR);
  assign Busy_o     = (state != IDLE) | ~FifoEmpty_i;

endmodule

// File: tb/tb_wbuf_drain.sv
// Directed bench for wbuf_drain with C_TIMEOUT=8, W_CNT=4. A small array
// FIFO model feeds the DUT; expected values are hand-computed per step.
module tb_wbuf_drain;
  localparam int W_ENTRY = 68;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fifo_empty;
  logic [W_ENTRY-1:0] fifo_data;
  logic               fifo_read;
  logic               hold = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic               flush_done, mem_valid, busy, error;
  logic [31:0]        mem_addr, mem_wdata;
  logic [3:0]         mem_wstrb;
  logic [3:0]         wr_count;

  int errors = 0, checks = 0;
  int pops = 0;

  logic [W_ENTRY-1:0] mem [0:31];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[4:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  wbuf_drain #(.C_TIMEOUT(8), .W_CNT(4)) dut (
    .sClk_i(clk), .sRst_i(rst), .FifoEmpty_i(fifo_empty), .FifoData_i(fifo_data),
    .FifoRead_o(fifo_read), .Hold_i(hold), .Flush_i(flush), .FlushDone_o(flush_done),
    .MemValid_o(mem_valid), .MemReady_i(mem_ready), .MemAddr_o(mem_addr),
    .MemWData_o(mem_wdata), .MemWStrb_o(mem_wstrb), .Busy_o(busy),
    .Error_o(error), .WrCount_o(wr_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem[wr_ptr[4:0]] = {a, d, s};
    wr_ptr++;
  endtask

  int p0;

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_rd", fifo_read, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_err", error, 0);
    chk("rst_cnt", wr_count, 0);
    chk("rst_fdone", flush_done, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // single entry
    mem_ready = 1'b1;
    push(32'h1000, 32'hDEADBEEF, 4'hF);
    #1;
    chk("one_rd", fifo_read, 1);
    tick();
    chk("one_valid", mem_valid, 1);
    chk("one_addr", mem_addr, 32'h1000);
    chk("one_data", mem_wdata, 32'hDEADBEEF);
    chk("one_strb", mem_wstrb, 4'hF);
    chk("one_rd2", fifo_read, 0);
    tick();
    chk("one_cnt", wr_count, 1);
    chk("one_idle", mem_valid, 0);
    chk("one_pops", pops, 1);

    // back-to-back: 4 entries, ready always high
    p0 = pops;
    for (int i = 0; i < 4; i++) push(32'h2000 + 4*i, 32'hA0 + i, 4'h3);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", mem_valid, 1);
      chk("b2b_addr", mem_addr, 32'h2000 + 4*i);
      chk("b2b_rd", fifo_read, (i < 3) ? 1 : 0);
      tick();
    end
    chk("b2b_done", mem_valid, 0);
    chk("b2b_cnt", wr_count, 5);
    chk("b2b_pops", pops - p0, 4);

    // backpressure: 5 stalled cycles, handshake on the 6th
    mem_ready = 1'b0;
    push(32'h3000, 32'h11111111, 4'h1);
    tick();
    push(32'h3004, 32'h22222222, 4'h2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", mem_valid, 1);
      chk("bp_addr", mem_addr, 32'h3000);
      chk("bp_data", mem_wdata, 32'h11111111);
      chk("bp_rd", fifo_read, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("bp_rd6", fifo_read, 1);
    tick();
    chk("bp_next", mem_addr, 32'h3004);
    chk("bp_cnt", wr_count, 6);
    tick();
    chk("bp_cnt2", wr_count, 7);
    chk("bp_idle", mem_valid, 0);

    // hold blocks pops; flush drains through it
    hold = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h4000 + 4*i, 32'hB0 + i, 4'hF);
    p0 = pops;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd", fifo_read, 0);
      chk("hold_valid", mem_valid, 0);
    end
    chk("hold_busy", busy, 1);
    flush = 1'b1;
    #1;
    chk("fl_rd", fifo_read, 1);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fl_addr", mem_addr, 32'h4000 + 4*i);
      chk("fl_fdone", flush_done, 0);
      tick();
    end
    chk("fl_fdone1", flush_done, 1);
    chk("fl_valid", mem_valid, 0);
    chk("fl_pops", pops - p0, 3);
    chk("fl_cnt", wr_count, 10);
    tick();
    chk("fl_fdone0", flush_done, 0);
    hold = 1'b0;

    // flush when idle and empty
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fe_fdone", flush_done, 1);
    tick();
    chk("fe_fdone0", flush_done, 0);

    // counter wrap: 17 writes after reset -> 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0 = pops;
    for (int i = 0; i < 17; i++) push(32'h5000 + i, i, 4'h1);
    repeat (19) tick();
    chk("wrap_cnt", wr_count, 1);
    chk("wrap_pops", pops - p0, 17);

    // reset during REQ
    mem_ready = 1'b0;
    push(32'h6000, 32'h66, 4'h6);
    tick();
    chk("rr_valid", mem_valid, 1);
    push(32'h6004, 32'h77, 4'h7);
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rr_rd", fifo_read, 0);
    tick();
    chk("rr_valid0", mem_valid, 0);
    chk("rr_addr0", mem_addr, 0);
    chk("rr_cnt0", wr_count, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rr_after", wr_count, 1);

    // watchdog: 8 unacknowledged REQ cycles -> ERR
    mem_ready = 1'b0;
    push(32'h7000, 32'h88, 4'h8);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("wd_valid", mem_valid, 1);
      chk("wd_err0", error, 0);
      tick();
    end
    chk("wd_err", error, 1);
    chk("wd_valid0", mem_valid, 0);
    push(32'h7004, 32'h99, 4'h9);
    mem_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("wd_rd", fifo_read, 0);
    tick();
    flush = 1'b0;
    repeat (3) begin
      chk("wd_fdone", flush_done, 0);
      tick();
    end
    chk("wd_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("wd_clr", error, 0);
    rst = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wbuf_drain.md
# wbuf_drain

Drain engine directly downstream of the cache write-buffer compare FIFO. It pops packed store entries (address, data, byte strobes) from the FIFO head and issues them as single-beat writes on a valid/ready memory port. It supports back-to-back issue, an upstream hold, a flush handshake, a stall watchdog and a wrapping write counter.

## Interface
- W_ADDR, 32, address width
- W_DATA, 32, data width
- W_STRB, W_DATA/8, byte-strobe width
- W_ENTRY, W_ADDR+W_DATA+W_STRB, FIFO entry width. Layout: addr in [W_ENTRY-1:W_DATA+W_STRB], data in [W_DATA+W_STRB-1:W_STRB], strb in [W_STRB-1:0].
- C_TIMEOUT, 256, number of unacknowledged MemValid_o cycles before the watchdog fires; 0 disables the watchdog
- W_CNT, 16, width of WrCount_o
- sClk_i  in  1  clock; single clock domain
- sRst_i  in  1  reset, synchronous, active-high
- FifoEmpty_i  in  1  FIFO empty flag
- FifoData_i  in  W_ENTRY  FIFO head entry; combinational and valid when FifoEmpty_i=0
- FifoRead_o  out  1  pop strobe; one entry removed per asserted cycle
- Hold_i  in  1  inhibit new pops (e.g. while the read path resolves a compare hit); does not affect an outstanding write
- Flush_i  in  1  single-cycle flush request
- FlushDone_o  out  1  one-cycle pulse when a flush completes
- MemValid_o  out  1  write request valid
- MemReady_i  in  1  memory accepts the request
- MemAddr_o / MemWData_o / MemWStrb_o  out  W_ADDR / W_DATA / W_STRB  registered request payload
- Busy_o  out  1  high when state is not IDLE or FifoEmpty_i=0
- Error_o  out  1  sticky watchdog error
- WrCount_o  out  W_CNT  number of completed writes, wraps modulo 2^W_CNT

## Operation
- States: IDLE, REQ, ERR.
- Pop condition: PopOk = ~FifoEmpty_i & (~Hold_i | FlushPend), where FlushPend = FlushPend_r | Flush_i. A pending flush overrides Hold_i.
- FifoRead_o is combinational:
  - In IDLE: FifoRead_o = PopOk.
  - In REQ: FifoRead_o = MemReady_i & PopOk.
  - In ERR: FifoRead_o = 0.
- On every pop, FifoData_i is captured into MemAddr_o, MemWData_o and MemWStrb_o at the same edge.
- IDLE, pop: go to REQ.
- REQ, MemReady_i=1 (handshake): WrCount_o increments. If a pop occurs in the same cycle, stay in REQ with the new payload (back-to-back). Otherwise go to IDLE.
- REQ, MemReady_i=0: payload and MemValid_o are held stable (no changes while valid and not ready).
- MemValid_o = 1 exactly when state is REQ.
- Watchdog (C_TIMEOUT>0):
  - The counter clears on every pop and every handshake, and increments on each REQ cycle with MemReady_i=0.
  - When the counter equals C_TIMEOUT-1 and MemReady_i=0, the block goes to ERR at the next edge.
- ERR is terminal until reset: MemValid_o=0, no pops, Error_o=1. Flush requests received in ERR never complete.
- Flush sequence:
  - Flush_i sets FlushPend_r.
  - Completion occurs when FlushPend is set, state is IDLE and FifoEmpty_i=1, or when state is REQ, a handshake occurs, FifoEmpty_i=1 and there is no pop.
  - On completion, FlushDone_o pulses for one cycle (registered, the cycle after the condition) and FlushPend_r clears.
  - Flush_i while a flush is already pending is absorbed.
  - A Flush_i in IDLE with the FIFO already empty produces FlushDone_o one cycle later.

## Timing
- Reset values (sync, sRst_i sampled high): state IDLE, MemValid_o=0, payload=0, Error_o=0, WrCount_o=0, FlushDone_o=0, FlushPend_r=0, watchdog=0.
- FifoRead_o is forced 0 while sRst_i=1.
- Reset mid-transaction drops the in-flight write. The popped entry is lost; this is accepted, since the FIFO is reset by the same reset.
- Latency: pop at edge N gives MemValid_o=1 in cycle N+1.
- Throughput: one write per cycle while MemReady_i=1 and the FIFO is non-empty.
- Hold_i asserting in REQ does not deassert MemValid_o; it only blocks the next pop.
- WrCount_o updates the edge after the handshake and wraps from 2^W_CNT-1 to 0.

## Test plan
- Single entry: FIFO holds {addr=0x1000, data=0xDEADBEEF, strb=0xF}, MemReady_i=1 -> FifoRead_o pulses for 1 cycle; next cycle MemValid_o=1 with that payload; WrCount_o=1; state returns to IDLE.
- Back-to-back: 4 entries, MemReady_i=1 always -> 4 consecutive MemValid_o cycles, 4 pops in 4 cycles, WrCount_o=4.
- Backpressure: MemReady_i=0 for 5 cycles -> MemValid_o and payload remain stable, no pop; handshake on cycle 6.
- Hold and flush: Hold_i=1 with 3 entries -> no pops. Then Flush_i pulse -> 3 writes drain despite Hold_i, and FlushDone_o pulses once after the last handshake.
- Watchdog: C_TIMEOUT=8, MemReady_i=0 forever -> ERR after 8 REQ cycles; MemValid_o=0, Error_o=1; later entries not popped; sRst_i clears Error_o.
- Counter wrap and reset: W_CNT=4 with 17 writes -> WrCount_o=1. sRst_i asserted during REQ -> next cycle all outputs at their reset values.
